// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Data-memory request/acknowledge bus between the MEM stage and data memory.
//   Handshake: the master raises req together with we/addr/wdata/be and holds
//   all of them stable until the cycle in which the slave pulses ack for one
//   cycle (rdata is valid in that same cycle); req drops on the following edge.
//   Ports (master view):
//     req   out  1   bus request
//     we    out  1   1 = write, 0 = read
//     addr  out  32  word-aligned address
//     wdata out  32  lane-replicated store data
//     be    out  4   byte enables
//     rdata in   32  read data, valid with ack
//     ack   in   1   one-cycle completion strobe
interface mem_wb_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access stage plus MEM/WB pipeline register of the RV32I core.
//   Issues loads/stores on the dmem bus, aligns and extends load data, builds
//   store byte enables, and holds upstream (stall) while an access is pending.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     valid_in        EX/MEM bundle valid
//     mem_read/write  load / store op
//     funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//     addr, wdata     byte address, store data
//     pc4_in, rd_in, regwrite_in, wbsel_in   bundle fields passed to WB
//     stall           combinational; upstream holds the bundle while high
//     dmem            data-memory bus (master)
//     wb_*            registered writeback bundle
//     mem_exc         one-cycle pulse: misaligned, illegal or timed out
//     dbg_state       current FSM state (0 = IDLE, 1 = WAIT)
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [31:0]           pc4_in,
  input  logic [4:0]            rd_in,
  input  logic                  regwrite_in,
  input  logic [1:0]            wbsel_in,
  output logic                  stall,
  mem_wb_stage_if.master        dmem,
  output logic                  wb_valid,
  output logic [31:0]           wb_alu,
  output logic [31:0]           wb_rdata,
  output logic [31:0]           wb_pc4,
  output logic [4:0]            wb_rd,
  output logic                  wb_regwrite,
  output logic [1:0]            wb_sel,
  output logic                  mem_exc,
  output logic                  dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] tmo_cnt;

  logic        is_mem, illegal, misaligned, bad;
  logic        expire;
  logic        issue, pass, reject, complete, cap;
  logic [31:0] cap_rdata;
  logic        cap_regwrite;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign dbg_state = state_q;

  // Operation decode: legality and alignment of the presented bundle.
  always_comb begin
    is_mem     = mem_read | mem_write;
    // 011/110/111 are never memory ops; unsigned variants exist only for loads.
    illegal    = (funct3 == 3'b011) || (funct3[2] && funct3[1]) ||
                 (mem_write && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad        = is_mem && (illegal || misaligned);
  end

  // Timeout fires in the last allowed WAIT cycle; an ack in that cycle wins.
  always_comb begin
    expire = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      expire = (state_q == S_WAIT) && !dmem.ack &&
               (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid_in && is_mem && !bad) state_d = S_WAIT;
      S_WAIT: if (dmem.ack || expire)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / strobe logic.
  always_comb begin
    issue        = (state_q == S_IDLE) && valid_in && is_mem && !bad;
    pass         = (state_q == S_IDLE) && valid_in && !is_mem;
    reject       = (state_q == S_IDLE) && valid_in && bad;
    complete     = (state_q == S_WAIT) && dmem.ack;
    cap          = pass || reject || complete || expire;
    cap_rdata    = (complete && mem_read) ? ld_data : 32'h0;
    cap_regwrite = (pass || complete) ? regwrite_in : 1'b0;
    // Gated by rst_n so the hold request disappears with reset, not at the next edge.
    stall        = rst_n && (issue || ((state_q == S_WAIT) && !dmem.ack && !expire));
  end

  // Store lane placement.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  // Load lane extraction and extension.
  always_comb begin
    ld_byte = 8'(dmem.rdata >> {addr[1:0], 3'b000});
    ld_half = addr[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.rdata;
    endcase
  end

  // Bus, writeback and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= 32'h0;
      dmem.wdata  <= 32'h0;
      dmem.be     <= 4'h0;
      wb_valid    <= 1'b0;
      wb_alu      <= 32'h0;
      wb_rdata    <= 32'h0;
      wb_pc4      <= 32'h0;
      wb_rd       <= 5'h0;
      wb_regwrite <= 1'b0;
      wb_sel      <= 2'h0;
      mem_exc     <= 1'b0;
      tmo_cnt     <= 32'h0;
    end else begin
      mem_exc <= reject || expire;

      if (issue) begin
        dmem.req   <= 1'b1;
        dmem.we    <= mem_write;
        dmem.addr  <= {addr[31:2], 2'b00};
        dmem.be    <= st_be;
        dmem.wdata <= mem_write ? st_wdata : 32'h0;
        tmo_cnt    <= 32'h0;
      end else if (complete || expire) begin
        dmem.req <= 1'b0;
      end else if (state_q == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 32'h1;
      end

      if (cap) begin
        wb_valid    <= 1'b1;
        wb_alu      <= addr;
        wb_rdata    <= cap_rdata;
        wb_pc4      <= pc4_in;
        wb_rd       <= rd_in;
        wb_regwrite <= cap_regwrite;
        wb_sel      <= wbsel_in;
      end else if (state_q == S_IDLE) begin
        // Idle cycle or memory issue: a bubble goes to writeback.
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] pc4_in = 32'h0;
  logic [4:0]  rd_in = 5'h0;
  logic        regwrite_in = 1'b0;
  logic [1:0]  wbsel_in = 2'b0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_alu;
  logic [31:0] wb_rdata;
  logic [31:0] wb_pc4;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic [1:0]  wb_sel;
  logic        mem_exc;
  logic        dbg_state;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .pc4_in      (pc4_in),
    .rd_in       (rd_in),
    .regwrite_in (regwrite_in),
    .wbsel_in    (wbsel_in),
    .stall       (stall),
    .dmem        (bus),
    .wb_valid    (wb_valid),
    .wb_alu      (wb_alu),
    .wb_rdata    (wb_rdata),
    .wb_pc4      (wb_pc4),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .wb_sel      (wb_sel),
    .mem_exc     (mem_exc),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] r, input logic rw, input logic [1:0] ws);
    valid_in    = 1'b1;
    mem_read    = rd_op;
    mem_write   = wr_op;
    funct3      = f3;
    addr        = a;
    wdata       = wd;
    pc4_in      = pc;
    rd_in       = r;
    regwrite_in = rw;
    wbsel_in    = ws;
  endtask

  task automatic idle_bundle;
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Load with ack one cycle after req rises.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    present(1'b1, 1'b0, f3, a, 32'h0, 32'h300, 5'd6, 1'b1, 2'b01);
    #1;
    chk({tag, " stall c0"}, 32'(stall), 32'h1);
    tick;
    chk({tag, " req"}, 32'(bus.req), 32'h1);
    chk({tag, " dmem_addr"}, bus.addr, {a[31:2], 2'b00});
    chk({tag, " we"}, 32'(bus.we), 32'h0);
    chk({tag, " stall c1"}, 32'(stall), 32'h1);
    chk({tag, " bubble"}, 32'(wb_valid), 32'h0);
    tick;
    bus.ack   = 1'b1;
    bus.rdata = rdata;
    #1;
    chk({tag, " stall ack"}, 32'(stall), 32'h0);
    tick;
    bus.ack = 1'b0;
    idle_bundle();
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'h1);
    chk({tag, " wb_rdata"}, wb_rdata, exp);
    chk({tag, " req drop"}, 32'(bus.req), 32'h0);
    chk({tag, " wb_regwrite"}, 32'(wb_regwrite), 32'h1);
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'd6);
    chk({tag, " wb_sel"}, 32'(wb_sel), 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    tick;
    tick;
    chk("rst req", 32'(bus.req), 32'h0);
    chk("rst be", 32'(bus.be), 32'h0);
    chk("rst wb_valid", 32'(wb_valid), 32'h0);
    chk("rst mem_exc", 32'(mem_exc), 32'h0);
    chk("rst state", 32'(dbg_state), 32'h0);
    chk("rst stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    tick;

    // ALU op passes through in one cycle.
    present(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h100, 5'd5, 1'b1, 2'b00);
    #1;
    chk("alu stall", 32'(stall), 32'h0);
    tick;
    idle_bundle();
    chk("alu wb_valid", 32'(wb_valid), 32'h1);
    chk("alu wb_alu", wb_alu, 32'h0000_1234);
    chk("alu wb_pc4", wb_pc4, 32'h100);
    chk("alu wb_rd", 32'(wb_rd), 32'd5);
    chk("alu wb_regwrite", 32'(wb_regwrite), 32'h1);
    chk("alu wb_rdata", wb_rdata, 32'h0);
    chk("alu req", 32'(bus.req), 32'h0);

    // Stray ack in IDLE is ignored.
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    chk("idle ack wb_valid", 32'(wb_valid), 32'h0);
    chk("idle ack state", 32'(dbg_state), 32'h0);

    // Loads.
    do_load("lb", 3'b000, 32'h203, 32'h80FF_1122, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80FF_1122, 32'h0000_0080);
    do_load("lhu", 3'b101, 32'h202, 32'h80FF_1122, 32'h0000_80FF);
    do_load("lh", 3'b001, 32'h202, 32'h80FF_1122, 32'hFFFF_80FF);
    do_load("lb1", 3'b000, 32'h201, 32'h80FF_1122, 32'h0000_0011);
    do_load("lw", 3'b010, 32'h204, 32'h8765_4321, 32'h8765_4321);

    // SH with ack in the fourth WAIT cycle (same cycle as timeout expiry).
    present(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h400, 5'd0, 1'b0, 2'b00);
    tick;
    chk("sh be", 32'(bus.be), 32'hC);
    chk("sh wdata", bus.wdata, 32'hABCD_ABCD);
    chk("sh we", 32'(bus.we), 32'h1);
    chk("sh addr", bus.addr, 32'h100);
    tick;
    chk("sh req c2", 32'(bus.req), 32'h1);
    tick;
    chk("sh req c3", 32'(bus.req), 32'h1);
    chk("sh stall c3", 32'(stall), 32'h1);
    tick;
    chk("sh req c4", 32'(bus.req), 32'h1);
    chk("sh addr c4", bus.addr, 32'h100);
    bus.ack = 1'b1;
    #1;
    chk("sh stall ack", 32'(stall), 32'h0);
    tick;
    bus.ack = 1'b0;
    idle_bundle();
    chk("sh wb_valid", 32'(wb_valid), 32'h1);
    chk("sh wb_regwrite", 32'(wb_regwrite), 32'h0);
    chk("sh wb_rdata", wb_rdata, 32'h0);
    chk("sh no exc", 32'(mem_exc), 32'h0);
    chk("sh req drop", 32'(bus.req), 32'h0);
    chk("sh wb_alu", wb_alu, 32'h102);

    // SB at offset 1, immediate ack.
    present(1'b0, 1'b1, 3'b000, 32'h001, 32'h5566_77AB, 32'h404, 5'd0, 1'b0, 2'b00);
    tick;
    chk("sb be", 32'(bus.be), 32'h2);
    chk("sb wdata", bus.wdata, 32'hABAB_ABAB);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    idle_bundle();
    chk("sb wb_valid", 32'(wb_valid), 32'h1);

    // Misaligned LW.
    present(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h500, 5'd9, 1'b1, 2'b01);
    #1;
    chk("mis stall", 32'(stall), 32'h0);
    tick;
    idle_bundle();
    chk("mis req", 32'(bus.req), 32'h0);
    chk("mis exc", 32'(mem_exc), 32'h1);
    chk("mis wb_valid", 32'(wb_valid), 32'h1);
    chk("mis wb_regwrite", 32'(wb_regwrite), 32'h0);
    tick;
    chk("mis exc pulse", 32'(mem_exc), 32'h0);
    chk("mis wb_valid off", 32'(wb_valid), 32'h0);

    // Illegal funct3 011 load.
    present(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 32'h504, 5'd9, 1'b1, 2'b01);
    #1;
    chk("ill stall", 32'(stall), 32'h0);
    tick;
    idle_bundle();
    chk("ill req", 32'(bus.req), 32'h0);
    chk("ill exc", 32'(mem_exc), 32'h1);
    chk("ill wb_valid", 32'(wb_valid), 32'h1);
    chk("ill wb_regwrite", 32'(wb_regwrite), 32'h0);
    tick;

    // Timeout: LW at 0x40, never acked.
    present(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h600, 5'd3, 1'b1, 2'b01);
    tick;
    chk("tmo stall c1", 32'(stall), 32'h1);
    tick;
    chk("tmo stall c2", 32'(stall), 32'h1);
    tick;
    chk("tmo stall c3", 32'(stall), 32'h1);
    tick;
    chk("tmo req c4", 32'(bus.req), 32'h1);
    chk("tmo stall c4", 32'(stall), 32'h0);
    tick;
    idle_bundle();
    chk("tmo req drop", 32'(bus.req), 32'h0);
    chk("tmo exc", 32'(mem_exc), 32'h1);
    chk("tmo wb_valid", 32'(wb_valid), 32'h1);
    chk("tmo wb_regwrite", 32'(wb_regwrite), 32'h0);
    chk("tmo state", 32'(dbg_state), 32'h0);
    present(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 32'h604, 5'd7, 1'b1, 2'b00);
    tick;
    idle_bundle();
    chk("post tmo wb_valid", 32'(wb_valid), 32'h1);
    chk("post tmo wb_alu", wb_alu, 32'h55);
    chk("post tmo wb_regwrite", 32'(wb_regwrite), 32'h1);
    chk("post tmo exc", 32'(mem_exc), 32'h0);

    // Reset in the middle of WAIT.
    present(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h700, 5'd4, 1'b1, 2'b01);
    tick;
    tick;
    chk("mid req before rst", 32'(bus.req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst mid req", 32'(bus.req), 32'h0);
    chk("rst mid wb_valid", 32'(wb_valid), 32'h0);
    chk("rst mid stall", 32'(stall), 32'h0);
    chk("rst mid state", 32'(dbg_state), 32'h0);
    idle_bundle();
    tick;
    tick;
    rst_n = 1'b1;

    // SW after reset.
    present(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h800, 5'd0, 1'b0, 2'b00);
    #1;
    chk("sw stall", 32'(stall), 32'h1);
    tick;
    chk("sw be", 32'(bus.be), 32'hF);
    chk("sw req", 32'(bus.req), 32'h1);
    chk("sw we", 32'(bus.we), 32'h1);
    chk("sw wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("sw addr", bus.addr, 32'h10);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    idle_bundle();
    chk("sw wb_valid", 32'(wb_valid), 32'h1);
    chk("sw req drop", 32'(bus.req), 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the RV32I core.
- Takes the EX/MEM bundle and runs loads and stores over a req/ack data-memory bus.
- Aligns and sign-extends load data, generates byte enables for stores, and stalls upstream while an access is outstanding.
- Its registered outputs feed the writeback 3:1 select directly:
  - WB_ALU → input A (SEL=00)
  - WB_RDATA → input B (SEL=01)
  - WB_PC4 → input C (SEL=10)
  - WB_SEL → SEL

Parameters:
TIMEOUT_CYCLES, 0, max cycles waiting for DMEM_ACK; 0 disables the timeout

Ports:
CLK  in  1  clock; all state changes on rising edge
RST_N  in  1  asynchronous active-low reset
VALID_IN  in  1  EX/MEM bundle valid
MEM_READ  in  1  load op
MEM_WRITE  in  1  store op (MEM_READ and MEM_WRITE never both set)
FUNCT3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
ADDR  in  32  byte address (ALU result)
WDATA  in  32  store data (rs2)
PC4_IN  in  32  PC+4
RD_IN  in  5  destination register
REGWRITE_IN  in  1  writes rd
WBSEL_IN  in  2  writeback select
STALL  out  1  combinational; upstream holds the bundle while high
DMEM_REQ  out  1  bus request
DMEM_WE  out  1  1 = write
DMEM_ADDR  out  32  word address ({ADDR[31:2],2'b00})
DMEM_WDATA  out  32  lane-replicated store data
DMEM_BE  out  4  byte enables
DMEM_RDATA  in  32  read data, valid with DMEM_ACK
DMEM_ACK  in  1  one-cycle completion strobe
WB_VALID  out  1  WB bundle valid
WB_ALU  out  32  registered ADDR
WB_RDATA  out  32  extended load data
WB_PC4  out  32  registered PC4_IN
WB_RD  out  5  registered rd
WB_REGWRITE  out  1  gated register-write enable
WB_SEL  out  2  registered WBSEL_IN
MEM_EXC  out  1  one-cycle pulse: misaligned, illegal or timed out

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - All registered outputs go to 0: DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE, all WB_* and MEM_EXC.
  - A reset during WAIT drops DMEM_REQ immediately; the pending op is discarded.
- FSM states: IDLE, WAIT.
- IDLE, VALID_IN=0: WB_VALID←0, WB_REGWRITE←0.
- IDLE, VALID_IN=1, non-memory op:
  - WB regs capture the bundle next edge; WB_RDATA←0; WB_VALID←1.
  - STALL=0. Latency 1 cycle.
- IDLE, memory op, legal and aligned:
  - STALL=1.
  - Next edge: DMEM_REQ←1, DMEM_WE←MEM_WRITE, DMEM_ADDR/DMEM_BE/DMEM_WDATA loaded.
  - WB_VALID←0 (bubble); state→WAIT.
- WAIT:
  - DMEM_* held stable.
  - STALL = ~DMEM_ACK.
  - On DMEM_ACK:
    - DMEM_REQ←0; WB regs capture the bundle.
    - Load: WB_RDATA←extracted DMEM_RDATA. Store: WB_RDATA←0.
    - WB_VALID←1; state→IDLE.
  - Minimum memory-op latency: REQ high 1 cycle after presentation, ACK in that same cycle, WB_VALID 2 cycles after presentation.
  - DMEM_ACK outside WAIT is ignored.
- Alignment and legality:
  - H/HU with ADDR[0]=1, or W with ADDR[1:0]≠00, is misaligned.
  - FUNCT3 011/110/111 with a memory op is illegal; so is a store with FUNCT3 100/101.
  - Either case: no bus access, STALL=0.
  - Next edge: WB bundle captured with WB_REGWRITE←0, WB_VALID←1, MEM_EXC←1 for one cycle.
- Store lanes (off=ADDR[1:0]):
  - SB: WDATA[7:0] replicated to all 4 lanes; BE=0001<<off.
  - SH: WDATA[15:0] replicated to both halves; BE=0011 if off=00, 1100 if off=10.
  - SW: BE=1111.
- Load extract: byte lane off or half lane ADDR[1], shifted to bit 0.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Timeout (TIMEOUT_CYCLES=N>0):
  - Counter cleared on WAIT entry.
  - If N cycles elapse in WAIT without ACK: DMEM_REQ←0, MEM_EXC pulse, WB_VALID←1, WB_REGWRITE←0, STALL=0 that cycle, state→IDLE.
  - An ACK in the same cycle as expiry wins.
- WB_REGWRITE = REGWRITE_IN on a normal completion, else 0.
- VALID_IN and the bundle are sampled only in IDLE or on the completion cycle; upstream must hold them while STALL=1.

Test Plan:
- ALU op: ADDR=0x0000_1234, PC4_IN=0x100, RD=5, WBSEL=00 → next cycle WB_VALID=1, WB_ALU=0x1234, WB_PC4=0x100, WB_RD=5, STALL never high, DMEM_REQ stays 0.
- LB at ADDR=0x203, ACK one cycle after REQ with RDATA=0x80FF_1122 → DMEM_ADDR=0x200, STALL high 2 cycles, WB_RDATA=0xFFFF_FF80; same with LBU → 0x0000_0080; LHU at 0x202 → 0x0000_80FF.
- SH at ADDR=0x102, WDATA=0x1234_ABCD, ACK delayed 3 cycles → DMEM_BE=1100, DMEM_WDATA=0xABCD_ABCD, DMEM_WE=1, REQ/ADDR stable for 4 cycles, WB_REGWRITE=0 after ACK.
- LW at ADDR=0x101 → no DMEM_REQ, MEM_EXC pulse 1 cycle, WB_VALID=1, WB_REGWRITE=0; FUNCT3=011 load → same response.
- TIMEOUT_CYCLES=4, LW at 0x40 with ACK never asserted → REQ drops after 4 WAIT cycles, MEM_EXC pulse, STALL released, state IDLE; next ALU op completes normally.
- RST_N low 2 cycles after REQ rises (mid-WAIT) → DMEM_REQ, WB_VALID and STALL go 0 without waiting for CLK; after release an SW at 0x10 issues BE=1111 normally.
